// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: holds one instruction from execute, aligns load data,
// selects the multiplier product, and offers the result to writeback and the decode forward path.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [133:0] es_to_ms_bus,
  input  logic [31:0]  data_sram_rdata,
  input  logic [63:0]  mul_result,
  input  logic         excp_flush,
  input  logic         ertn_flush,
  output logic         ms_to_ws_valid,
  output logic [125:0] ms_to_ws_bus,
  output logic [37:0]  ms_to_ds_forward_bus,
  output logic         ms_to_es_excp
);

  logic         ms_valid_q, ms_valid_d;
  logic         entry_q, entry_d;
  logic [133:0] bus_q, bus_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;
  logic         rdata_buf_valid_q, rdata_buf_valid_d;

  logic         flush;
  logic         mem_sign_ext;
  logic [6:0]   excp_num;
  logic         csr_we;
  logic [13:0]  csr_idx;
  logic [31:0]  csr_result;
  logic         ertn;
  logic         excp;
  logic [1:0]   mem_size;
  logic [1:0]   mul_sel;
  logic         load_op;
  logic         gr_we;
  logic [4:0]   dest;
  logic [31:0]  result;
  logic [31:0]  pc;
  logic         unused_mdop;

  logic [31:0]  rdata_eff;
  logic [7:0]   load_byte;
  logic [15:0]  load_half;
  logic [31:0]  load_data;
  logic [31:0]  final_result;
  logic         forward_enable;

  assign mem_sign_ext = bus_q[133];
  assign excp_num     = bus_q[132:126];
  assign csr_we       = bus_q[125];
  assign csr_idx      = bus_q[124:111];
  assign csr_result   = bus_q[110:79];
  assign ertn         = bus_q[78];
  assign excp         = bus_q[77];
  assign mem_size     = bus_q[76:75];
  assign mul_sel      = bus_q[72:71];
  assign load_op      = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign result       = bus_q[63:32];
  assign pc           = bus_q[31:0];
  assign unused_mdop  = ^bus_q[74:73];

  assign flush          = excp_flush | ertn_flush;
  assign ms_allowin     = !ms_valid_q | ws_allowin;
  assign ms_to_ws_valid = ms_valid_q;

  // SRAM data is only valid in the entry cycle; a stalled load keeps its own copy until handoff.
  always_comb begin
    ms_valid_d        = ms_valid_q;
    entry_d           = 1'b0;
    bus_d             = bus_q;
    rdata_buf_d       = rdata_buf_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      entry_d    = es_to_ms_valid;
      bus_d      = es_to_ms_bus;
    end
    if (ms_valid_q & ws_allowin) begin
      rdata_buf_valid_d = 1'b0;
    end else if (ms_valid_q & entry_q & load_op & !ws_allowin) begin
      rdata_buf_d       = data_sram_rdata;
      rdata_buf_valid_d = 1'b1;
    end
    if (flush) begin
      ms_valid_d        = 1'b0;
      entry_d           = 1'b0;
      rdata_buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q        <= 1'b0;
      entry_q           <= 1'b0;
      rdata_buf_valid_q <= 1'b0;
    end else begin
      ms_valid_q        <= ms_valid_d;
      entry_q           <= entry_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

  assign rdata_eff = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

  always_comb begin
    load_byte = rdata_eff[7:0];
    case (result[1:0])
      2'b00: load_byte = rdata_eff[7:0];
      2'b01: load_byte = rdata_eff[15:8];
      2'b10: load_byte = rdata_eff[23:16];
      2'b11: load_byte = rdata_eff[31:24];
      default: load_byte = rdata_eff[7:0];
    endcase
    load_half = result[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    load_data = '0;
    case (mem_size)
      2'b00: load_data = rdata_eff;
      2'b01: load_data = {{24{mem_sign_ext & load_byte[7]}}, load_byte};
      2'b10: load_data = {{16{mem_sign_ext & load_half[15]}}, load_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    final_result = result;
    if (load_op) begin
      final_result = load_data;
    end else if (mul_sel[0]) begin
      final_result = mul_result[31:0];
    end else if (mul_sel[1]) begin
      final_result = mul_result[63:32];
    end
  end

  assign forward_enable       = ms_valid_q & gr_we & (dest != 5'd0);
  assign ms_to_ds_forward_bus = {forward_enable, dest, final_result};
  assign ms_to_es_excp        = ms_valid_q & (excp | ertn);

  assign ms_to_ws_bus = {excp_num, csr_we, csr_idx, csr_result, ertn, excp,
                         gr_we & !excp, dest, final_result, pc};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load alignment, stall buffering,
// multiplier selection, flushes, forwarding and exception signalling.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [133:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic [63:0]  mul_result;
  logic         excp_flush;
  logic         ertn_flush;
  logic         ms_to_ws_valid;
  logic [125:0] ms_to_ws_bus;
  logic [37:0]  ms_to_ds_forward_bus;
  logic         ms_to_es_excp;

  int n_tests;
  int n_fail;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ws_allowin           (ws_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .data_sram_rdata      (data_sram_rdata),
    .mul_result           (mul_result),
    .excp_flush           (excp_flush),
    .ertn_flush           (ertn_flush),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .ms_to_es_excp        (ms_to_es_excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] mk(input logic sign, input logic [6:0] enum_v,
                                      input logic cwe, input logic [13:0] cidx,
                                      input logic [31:0] cres, input logic ertn,
                                      input logic excp, input logic [1:0] size,
                                      input logic [3:0] mdop, input logic load,
                                      input logic grwe, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {sign, enum_v, cwe, cidx, cres, ertn, excp, size, mdop, load, grwe, dest, res, pc};
  endfunction

  function automatic logic [133:0] mkld(input logic sign, input logic [1:0] size,
                                        input logic [1:0] addr);
    return mk(sign, 7'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, size, 4'h0, 1'b1, 1'b1, 5'd3,
              {30'h0400_0000, addr}, 32'h1C00_0100);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [133:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    ws_allowin     = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, 7'h1, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, 2'b00, 4'h0, 1'b0,
                        1'b1, 5'd9, 32'h1234, 32'h0);
    tick();
    tick();
    reset          = 1'b0;
    es_to_ms_valid = 1'b0;
    #1;
    n_tests++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", ms_to_ws_valid);
    end
    n_tests++;
    if (ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL reset_allowin got %b want 1", ms_allowin);
    end
    n_tests++;
    if (ms_to_ds_forward_bus[37] !== 1'b0) begin
      n_fail++; $display("FAIL reset_fwd_en got %b want 0", ms_to_ds_forward_bus[37]);
    end
    n_tests++;
    if (ms_to_es_excp !== 1'b0) begin
      n_fail++; $display("FAIL reset_excp got %b want 0", ms_to_es_excp);
    end
  endtask

  task automatic test_load_align();
    logic        sv [9];
    logic [1:0]  zv [9];
    logic [1:0]  av [9];
    logic [31:0] rv [9];
    logic [31:0] ev [9];
    sv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    zv = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
    av = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
    rv = '{32'h80FF_1234, 32'h80FF_1234, 32'h9ABC_0000, 32'h9ABC_0000, 32'h80FF_1234,
           32'h1234_8001, 32'hFFFF_FFFF, 32'h1234_56F0, 32'h80FF_1234};
    ev = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_9ABC, 32'h9ABC_0000, 32'h0000_0012,
           32'hFFFF_8001, 32'h0000_0000, 32'h0000_00F0, 32'hFFFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      issue(mkld(sv[i], zv[i], av[i]));
      data_sram_rdata = rv[i];
      #1;
      n_tests++;
      if (ms_to_ws_bus[63:32] !== ev[i]) begin
        n_fail++;
        $display("FAIL load_align[%0d] got %h want %h", i, ms_to_ws_bus[63:32], ev[i]);
      end
    end
    n_tests++;
    if (ms_to_ws_bus[31:0] !== 32'h1C00_0100 || ms_to_ws_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_pc got pc=%h v=%b want pc=1c000100 v=1", ms_to_ws_bus[31:0],
               ms_to_ws_valid);
    end
  endtask

  task automatic test_stall();
    issue(mkld(1'b0, 2'b00, 2'd0));
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    #1;
    n_tests++;
    if (ms_allowin !== 1'b0 || ms_to_ws_bus[63:32] !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL stall_entry got allowin=%b res=%h want 0 11111111", ms_allowin,
               ms_to_ws_bus[63:32]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'h2222_2222;
      #1;
      n_tests++;
      if (ms_to_ws_bus[63:32] !== 32'h1111_1111 || ms_to_ws_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got res=%h v=%b want 11111111 1", c,
                 ms_to_ws_bus[63:32], ms_to_ws_valid);
      end
    end
    ws_allowin = 1'b1;
    #1;
    n_tests++;
    if (ms_to_ws_bus[63:32] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL stall_handoff got %h want 11111111", ms_to_ws_bus[63:32]);
    end
    tick();
    n_tests++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_leave got %b want 0", ms_to_ws_valid);
    end
    issue(mkld(1'b0, 2'b00, 2'd0));
    data_sram_rdata = 32'h3333_3333;
    #1;
    n_tests++;
    if (ms_to_ws_bus[63:32] !== 32'h3333_3333) begin
      n_fail++; $display("FAIL stall_buf_cleared got %h want 33333333", ms_to_ws_bus[63:32]);
    end
  endtask

  task automatic test_mul();
    logic [3:0]  ops [4];
    logic [31:0] ev  [4];
    ops = '{4'b0010, 4'b0001, 4'b1100, 4'b0000};
    ev  = '{32'h0000_0005, 32'h0000_0003, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    mul_result = 64'h0000_0005_0000_0003;
    for (int i = 0; i < 4; i++) begin
      issue(mk(1'b0, 7'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 2'b00, ops[i], 1'b0, 1'b1,
               5'd4, 32'hDEAD_BEEF, 32'h0));
      n_tests++;
      if (ms_to_ws_bus[63:32] !== ev[i]) begin
        n_fail++;
        $display("FAIL mul_sel[%0d] got %h want %h", i, ms_to_ws_bus[63:32], ev[i]);
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      issue(mkld(1'b0, 2'b00, 2'd0));
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'hAAAA_AAAA;
      tick();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mkld(1'b0, 2'b00, 2'd0);
      excp_flush     = (k == 0);
      ertn_flush     = (k == 1);
      tick();
      es_to_ms_valid = 1'b0;
      excp_flush     = 1'b0;
      ertn_flush     = 1'b0;
      #1;
      n_tests++;
      if (ms_to_ws_valid !== 1'b0 || ms_to_ds_forward_bus[37] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush[%0d] got v=%b fwd=%b want 0 0", k, ms_to_ws_valid,
                 ms_to_ds_forward_bus[37]);
      end
      issue(mkld(1'b0, 2'b00, 2'd0));
      data_sram_rdata = 32'h5555_5555;
      #1;
      n_tests++;
      if (ms_to_ws_bus[63:32] !== 32'h5555_5555) begin
        n_fail++;
        $display("FAIL flush_buf[%0d] got %h want 55555555", k, ms_to_ws_bus[63:32]);
      end
    end
  endtask

  task automatic test_fwd_excp();
    logic [55:0] exp_hi;
    issue(mk(1'b0, 7'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 5'd0,
             32'h0000_00AB, 32'h0));
    n_tests++;
    if (ms_to_ds_forward_bus[37] !== 1'b0) begin
      n_fail++; $display("FAIL fwd_dest0 got %b want 0", ms_to_ds_forward_bus[37]);
    end
    issue(mk(1'b0, 7'h0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 5'd5,
             32'h0000_00AB, 32'h0));
    n_tests++;
    if (ms_to_ds_forward_bus !== {1'b1, 5'd5, 32'h0000_00AB}) begin
      n_fail++; $display("FAIL fwd_dest5 got %h want 25000000ab", ms_to_ds_forward_bus);
    end
    issue(mk(1'b0, 7'h2A, 1'b1, 14'h0123, 32'hCAFE_BABE, 1'b0, 1'b1, 2'b00, 4'h0, 1'b0,
             1'b1, 5'd7, 32'h0, 32'h0));
    exp_hi = {7'h2A, 1'b1, 14'h0123, 32'hCAFE_BABE, 1'b0, 1'b1};
    n_tests++;
    if (ms_to_es_excp !== 1'b1 || ms_to_ws_bus[69] !== 1'b0) begin
      n_fail++;
      $display("FAIL excp_flags got excp=%b gr_we=%b want 1 0", ms_to_es_excp,
               ms_to_ws_bus[69]);
    end
    n_tests++;
    if (ms_to_ws_bus[125:70] !== exp_hi) begin
      n_fail++; $display("FAIL excp_fields got %h want %h", ms_to_ws_bus[125:70], exp_hi);
    end
    issue(mk(1'b0, 7'h0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 5'd0,
             32'h0, 32'h0));
    n_tests++;
    if (ms_to_es_excp !== 1'b1) begin
      n_fail++; $display("FAIL ertn_excp got %b want 1", ms_to_es_excp);
    end
  endtask

  task automatic test_reset_mid_stall();
    issue(mkld(1'b0, 2'b00, 2'd0));
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'hBBBB_BBBB;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall got v=%b allowin=%b want 0 1", ms_to_ws_valid, ms_allowin);
    end
    issue(mkld(1'b0, 2'b00, 2'd0));
    data_sram_rdata = 32'h7777_7777;
    #1;
    n_tests++;
    if (ms_to_ws_bus[63:32] !== 32'h7777_7777) begin
      n_fail++; $display("FAIL rst_stall_buf got %h want 77777777", ms_to_ws_bus[63:32]);
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    data_sram_rdata = '0;
    mul_result      = '0;
    excp_flush      = 1'b0;
    ertn_flush      = 1'b0;
    test_reset();
    test_load_align();
    test_stall();
    test_mul();
    test_flush();
    test_fwd_excp();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 ws_allowin  input  1  writeback stage can accept this cycle.
REQ-004 ms_allowin  output  1  mem stage can accept from execute.
REQ-005 es_to_ms_valid  input  1  execute offers an instruction.
REQ-006 es_to_ms_bus  input  134  fields: [133] mem_sign_ext, [132:126] excp_num, [125] csr_we, [124:111] csr_idx, [110:79] csr_result, [78] ertn, [77] excp, [76:75] mem_size, [74:71] mul_div_op, [70] load_op, [69] gr_we, [68:64] dest, [63:32] result, [31:0] pc.
REQ-007 data_sram_rdata  input  32  synchronous SRAM read data; valid the cycle after the address is issued by execute.
REQ-008 mul_result  input  64  multiplier product for the instruction held in this stage.
REQ-009 excp_flush, ertn_flush  input  1 each  pipeline flush requests.
REQ-010 ms_to_ws_valid  output  1  instruction offered to writeback.
REQ-011 ms_to_ws_bus  output  126  fields: [125:119] excp_num, [118] csr_we, [117:104] csr_idx, [103:72] csr_result, [71] ertn, [70] excp, [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
REQ-012 ms_to_ds_forward_bus  output  38  {forward_enable, dest[4:0], final_result[31:0]}.
REQ-013 ms_to_es_excp  output  1  held instruction carries excp or ertn; execute uses it to suppress store enables.

Function
REQ-014 Handshake: ms_ready_go SHALL be 1; ms_allowin = !ms_valid | ws_allowin; ms_to_ws_valid = ms_valid.
REQ-015 When ms_allowin, ms_valid SHALL load es_to_ms_valid and the bus register SHALL load es_to_ms_bus; otherwise both hold.
REQ-016 excp_flush or ertn_flush SHALL clear ms_valid next cycle, with priority over loading.
REQ-017 Read-data buffer: in the first cycle an instruction is held (entry cycle), if ms_valid & load_op & !ws_allowin, data_sram_rdata SHALL be captured into rdata_buf and rdata_buf_valid set.
REQ-018 rdata_buf_valid SHALL clear when the held instruction leaves (ms_valid & ws_allowin) or on flush or reset.
REQ-019 Effective read data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
REQ-020 Load alignment: byte lane selected by result[1:0]; halfword lane by result[1] (00 -> [15:0], 10 -> [31:16]).
REQ-021 mem_size 00 word (no shift), 01 byte, 10 halfword; 11 SHALL yield 0.
REQ-022 mem_sign_ext=1 sign-extends the selected byte/halfword to 32 bits; 0 zero-extends.
REQ-023 final_result priority: load_op -> load data; else mul_div_op[0] -> mul_result[31:0]; else mul_div_op[1] -> mul_result[63:32]; else result. mul_div_op[3:2] SHALL NOT alter result.
REQ-024 forward_enable = ms_valid & gr_we & (dest != 0).
REQ-025 ms_to_es_excp = ms_valid & (excp | ertn).
REQ-026 An instruction with excp=1 SHALL pass all csr and excp fields through unchanged; gr_we SHALL be forced to 0 on the outgoing bus.
REQ-027 Stall of any length SHALL keep final_result stable for the held load.

Reset
REQ-028 After reset: ms_valid=0, rdata_buf_valid=0, ms_allowin=1, ms_to_ws_valid=0, forward_enable=0, ms_to_es_excp=0; bus register contents are don't-care but SHALL NOT affect outputs while ms_valid=0.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction and buffer in one cycle.

Verification
REQ-030 ld.b, result[1:0]=11, rdata=0x80FF_1234, sign_ext=1 -> final_result 0xFFFF_FF80; sign_ext=0 -> 0x0000_0080.
REQ-031 ld.h, result[1:0]=10, rdata=0x9ABC_0000, sign_ext=0 -> 0x0000_9ABC; ld.w -> rdata unchanged.
REQ-032 ld.w entry with ws_allowin=0 for 3 cycles, rdata changes 0x1111_1111 -> 0x2222_2222 after entry -> final_result stays 0x1111_1111 until handoff; buffer cleared after.
REQ-033 mul_div_op=0010, mul_result=0x0000_0005_0000_0003 -> final_result 0x0000_0005; 0001 -> 0x0000_0003.
REQ-034 Held valid load with excp_flush asserted same cycle as es_to_ms_valid=1 -> next cycle ms_valid=0, forward_enable=0, rdata_buf_valid=0.
REQ-035 gr_we=1, dest=0 -> forward_enable=0; instruction with excp=1 -> ms_to_es_excp=1, outgoing gr_we=0.
